dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port, 1-cycle-latency data memory between the processor core's load/store path (port 0) and an external loader/debug master (port 1). It sits between the core's memory-access glue and the data memory instance. Round-robin arbitration applies in normal operation. Port 1 may lock the memory for bounded bursts during program/data loading, with a forced yield so the core is never starved.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 10, word-address width (matches 1024-word data memory)
- MAX_BURST, 16, maximum beats port 1 may hold a lock (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- p0_valid / p1_valid  in  1  request valid
- p0_ready / p1_ready  out  1  request accepted this cycle (combinational)
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_WIDTH  word address
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data
- p1_lock  in  1  port 1 requests exclusive burst ownership
- p0_rsp_valid / p1_rsp_valid  out  1  read data valid
- p0_rsp_rdata / p1_rsp_rdata  out  DATA_WIDTH  read data
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_read_en / mem_write_en  out  1  memory strobes
- mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_read_en
- arb_state  out  2  00 ARB, 01 LOCK, 10 YIELD

## Operation
- Beat accepted on port n when pN_valid & pN_ready. At most one beat per cycle.
- ARB state: if only one port valid, grant it. If both valid, grant the port not granted last (last_grant register, updated on every accepted beat).
- ARB→LOCK when a port 1 beat is accepted with p1_lock=1. burst_cnt=1.
- LOCK: p1_ready=p1_valid, p0_ready=0. burst_cnt increments on each accepted port 1 beat.
  - p1_lock sampled low → ARB, last_grant=1.
  - Accepted beat makes burst_cnt==MAX_BURST → YIELD.
- YIELD (exactly one cycle): p0_ready=p0_valid, p1_ready=0, then ARB with last_grant=1. Port 1 must release and reassert to relock.
- Memory drive: mem_addr/mem_wdata come from the granted port, 0 when no grant. mem_read_en = accept & ~we; mem_write_en = accept & we.
- Responses: a registered tag (valid + port id) records each accepted read. Next cycle the owning pN_rsp_valid=1 and pN_rsp_rdata=mem_rdata; the other port's rdata=0. Writes produce no response.
- Back-to-back reads: one response per cycle, in order.
- Valid not accepted: the requester holds the request; the arbiter does not buffer it.

## Timing
- Request path is combinational, valid→ready→mem strobes in the same cycle. Read latency is 1 cycle from accept to rsp_valid.
- Reset values:
  - arb_state=ARB, last_grant=1 (core wins the first tie), burst_cnt=0, response tag cleared.
  - All rsp_valid=0, all rdata=0.
  - Strobes 0 while no request is valid.
- Reset mid-burst or with a read in flight: state returns to ARB immediately and the pending response is dropped; no rsp_valid after rst_n rises.
- Simultaneous p1_lock drop and MAX_BURST-th beat: YIELD takes priority.
- burst_cnt saturates at MAX_BURST and never wraps.

## Test plan
- Reset, both valid reads (p0 addr 5, p1 addr 9): p0 granted cycle 0, p1 cycle 1. p0_rsp_valid in cycle 1 and p1_rsp_valid in cycle 2, each with the correct mem_rdata.
- Both ports continuously valid for 8 cycles in ARB: grants alternate p0,p1,p0,… and mem_write_en follows each port's we.
- p1 lock burst of 5 writes to addrs 0–4 while p0 is valid: p0_ready=0 throughout. p1_lock drop → ARB and p0 granted the next cycle.
- p1 holds lock and valid for 20 beats with MAX_BURST=16: exactly 16 p1 beats, then one YIELD cycle with p0 granted (or idle), then ARB alternation. arb_state sequence is 01…10,00.
- Read accepted on p1, rst_n pulsed low in the following cycle: no p1_rsp_valid, arb_state=00, outputs at reset values.
- Write 0xDEADBEEF from p0 to addr 3, then p1 reads addr 3: p1_rsp_rdata=0xDEADBEEF one cycle after its accept.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, 1-cycle-latency data memory between the
// core load/store path (port 0) and an external loader/debug master (port 1).
// Round-robin arbitration in normal operation. Port 1 may lock the memory for
// bounded bursts, and a forced one-cycle yield keeps the core from starving.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic                  p1_lock,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            arb_state
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'b00,
    ST_LOCK  = 2'b01,
    ST_YIELD = 2'b10
  } arb_state_e;

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;   // 1 = port 1 had the last beat
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             relock_block_q, relock_block_d; // set after a yield until p1_lock drops
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_port_q, rsp_port_d;
  logic             grant0, grant1;

  // Grant selection: round-robin in ARB, port 1 only in LOCK, port 0 only in YIELD
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (p0_valid && p1_valid) begin
          grant0 = last_grant_q;
          grant1 = ~last_grant_q;
        end else begin
          grant0 = p0_valid;
          grant1 = p1_valid;
        end
      end
      ST_LOCK:  grant1 = p1_valid;
      ST_YIELD: grant0 = p0_valid;
      default: ;
    endcase
  end

  assign p0_ready     = grant0;
  assign p1_ready     = grant1;
  assign mem_addr     = grant1 ? p1_addr  : (grant0 ? p0_addr  : '0);
  assign mem_wdata    = grant1 ? p1_wdata : (grant0 ? p0_wdata : '0);
  assign mem_read_en  = (grant0 & ~p0_we) | (grant1 & ~p1_we);
  assign mem_write_en = (grant0 &  p0_we) | (grant1 &  p1_we);
  assign arb_state    = state_q;

  assign p0_rsp_valid = rsp_valid_q & ~rsp_port_q;
  assign p1_rsp_valid = rsp_valid_q &  rsp_port_q;
  assign p0_rsp_rdata = p0_rsp_valid ? mem_rdata : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? mem_rdata : '0;

  // Next-state logic for the lock FSM, round-robin pointer, burst counter and read tag
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    burst_cnt_d    = burst_cnt_q;
    relock_block_d = relock_block_q & p1_lock;
    rsp_valid_d    = mem_read_en;
    rsp_port_d     = grant1;

    if (grant0) last_grant_d = 1'b0;
    if (grant1) last_grant_d = 1'b1;

    unique case (state_q)
      ST_ARB: begin
        burst_cnt_d = '0;
        if (grant1 && p1_lock && !relock_block_q) begin
          state_d     = ST_LOCK;
          burst_cnt_d = CNT_W'(1);
        end
      end
      ST_LOCK: begin
        if (grant1 && burst_cnt_q != MAX_CNT) burst_cnt_d = burst_cnt_q + CNT_W'(1);
        if (grant1 && burst_cnt_q == LAST_CNT) begin
          state_d = ST_YIELD;
        end else if (!p1_lock) begin
          state_d      = ST_ARB;
          last_grant_d = 1'b1;
          burst_cnt_d  = '0;
        end
      end
      ST_YIELD: begin
        state_d        = ST_ARB;
        last_grant_d   = 1'b1;
        burst_cnt_d    = '0;
        relock_block_d = p1_lock;
      end
      default: state_d = ST_ARB;
    endcase
  end

  // State registers; reset drops any in-flight read response immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_ARB;
      last_grant_q   <= 1'b1;
      burst_cnt_q    <= '0;
      relock_block_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_port_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      burst_cnt_q    <= burst_cnt_d;
      relock_block_q <= relock_block_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_port_q     <= rsp_port_d;
    end
  end

endmodule
